gray_updown_counter: RTL and testbench
======================================

Name: gray_updown_counter

Overview:
Parametrised up/down counter that steps in Gray code. It keeps the binary count and the matching Gray code registered together, so every output is glitch-free and consistent on each cycle. It generalises the team's fixed 4-bit combinational Gray/binary converter to any width and adds the following:
- enable and direction control
- synchronous load
- wrap or saturate mode
- terminal and wrap flags

It sits in front of pointer and position logic that needs single-bit-change codes.

Parameters:
WIDTH, 4, counter and code width in bits (>=2)
WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end values

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of bin_out
terminal  output  1  registered; 1 when bin_out is the end value in the current up direction (all-ones if up=1, zero if up=0)
wrap  output  1  registered one-cycle pulse on a wrap-around step

Behaviour:
- Clocking and reset: single clock domain; all state changes on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: bin_out=0, gray_out=0, wrap=0, terminal=0.
- Priority per cycle: rst > load > en > hold.
- rst=1: all outputs take their reset values on that edge, including mid-count or mid-load.
- load=1: bin_out<=load_val and gray_out<=load_val^(load_val>>1); wrap<=0; en and up are ignored.
- en=1, up=1: bin_next = bin_out+1, modulo 2^WIDTH.
  - At all-ones with WRAP=1: next value is 0 and wrap<=1.
  - At all-ones with WRAP=0: value holds and wrap stays 0.
- en=1, up=0: bin_next = bin_out-1.
  - At 0 with WRAP=1: next value is all-ones and wrap<=1.
  - At 0 with WRAP=0: value holds.
- en=0 (no load): hold both codes; wrap<=0.
- gray_out is always computed from the next binary value and registered on the same edge as bin_out. Latency from en to updated outputs is 1 cycle. No cycle may show a mismatched bin_out/gray_out pair.
- Gray invariant: each counting step (not load, not reset) changes exactly one bit of gray_out, including wrap steps. A saturated hold changes no bits.
- terminal:
  - Computed from the registered next value and the current up input.
  - Also updated on load and hold cycles, so it is valid one cycle after any change.
- Arithmetic is unsigned and width-exact; no carry-out port.
- Width rule: gray = bin ^ (bin>>1); bin[i] = XOR of gray[WIDTH-1:i].

Optional Feature:
GRAY_DECODE_EN
- Defined: adds a pipelined Gray-to-binary decode port.
  - Extra ports: gray_in (input, WIDTH), gray_in_vld (input, 1), bin_dec (output, WIDTH), bin_dec_vld (output, 1).
  - bin_dec <= XOR-prefix decode of gray_in and bin_dec_vld <= gray_in_vld, with exactly 1-cycle latency.
  - bin_dec holds its last value when gray_in_vld=0.
  - Reset clears both bin_dec and bin_dec_vld to 0.
  - The decoder is independent of the counter.
- Not defined: these ports and their logic do not exist. Counter behaviour is identical in both builds.

Test Plan:
1. WIDTH=4, WRAP=1; reset, then en=1, up=1 for 17 cycles.
   - gray_out sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
   - bin_out runs 0..15 then 0; wrap=1 only on the 15->0 cycle; terminal=1 while bin_out=15.
2. WIDTH=4, WRAP=1; from 0 apply en=1, up=0.
   - bin_out=15, gray_out=1000, wrap=1 for one cycle; then 14 / 1001.
3. WIDTH=4, WRAP=0.
   - Count up to 15 with en held high: bin_out stays 15, gray_out stays 1000, wrap never 1, terminal=1.
   - Switch up=0: next value 14, terminal=0.
4. load=1, load_val=9 with en=1 in the same cycle.
   - Next cycle: bin_out=1001, gray_out=1101; counting resumes from 9.
5. rst=1 asserted mid-count (bin_out=6) together with load=1.
   - Next cycle: all outputs 0; bin_out does not take the load value.
6. WIDTH=8 with GRAY_DECODE_EN defined; sweep gray_in over all 256 codes with gray_in_vld=1.
   - bin_dec equals the decode one cycle later.
   - Counter random-walk check: bin_out equals gray2bin(gray_out) every cycle, and exactly one gray bit changes per counting step.

Source files
------------

// File: rtl/gray_updown_counter.sv
// Parametrised up/down counter that keeps its binary count and Gray code registered together, with load, wrap/saturate, terminal and wrap flags.
// Optional macro GRAY_DECODE_EN adds an independent 1-cycle pipelined Gray-to-binary decode port.
module gray_updown_counter #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             terminal,
   output logic             wrap
`ifdef GRAY_DECODE_EN
   ,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             gray_in_vld,
   output logic [WIDTH-1:0] bin_dec,
   output logic             bin_dec_vld
`endif
);

   logic [WIDTH-1:0] bin_reg, bin_next;
   logic [WIDTH-1:0] gray_reg, gray_next;
   logic             terminal_reg, terminal_next;
   logic             wrap_reg, wrap_next;
   logic             at_max, at_min;

   assign at_max = &bin_reg;
   assign at_min = ~|bin_reg;

   always_comb begin
      bin_next  = bin_reg;
      wrap_next = 1'b0;
      if (load) begin
         bin_next = load_val;
      end else if (en) begin
         if (up) begin
            if (!at_max) begin
               bin_next = bin_reg + WIDTH'(1);
            end else if (WRAP) begin
               bin_next  = '0;
               wrap_next = 1'b1;
            end
         end else begin
            if (!at_min) begin
               bin_next = bin_reg - WIDTH'(1);
            end else if (WRAP) begin
               bin_next  = '1;
               wrap_next = 1'b1;
            end
         end
      end
      // terminal looks at the value about to be registered, so it is valid with it
      terminal_next = up ? (&bin_next) : (~|bin_next);
   end

   // Gray encode of the next value, registered on the same edge as the binary count
   generate
      for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_enc
         assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
      end
   endgenerate
   assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_reg      <= '0;
         gray_reg     <= '0;
         terminal_reg <= 1'b0;
         wrap_reg     <= 1'b0;
      end else begin
         bin_reg      <= bin_next;
         gray_reg     <= gray_next;
         terminal_reg <= terminal_next;
         wrap_reg     <= wrap_next;
      end
   end

   assign bin_out  = bin_reg;
   assign gray_out = gray_reg;
   assign terminal = terminal_reg;
   assign wrap     = wrap_reg;

`ifdef GRAY_DECODE_EN
   logic [WIDTH-1:0] dec_next;
   logic [WIDTH-1:0] dec_reg;
   logic             dec_vld_reg;

   // Each binary bit is the XOR of all Gray bits at and above it
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
         assign dec_next[gi] = ^gray_in[WIDTH-1:gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_reg     <= '0;
         dec_vld_reg <= 1'b0;
      end else begin
         dec_vld_reg <= gray_in_vld;
         if (gray_in_vld) begin
            dec_reg <= dec_next;
         end
      end
   end

   assign bin_dec     = dec_reg;
   assign bin_dec_vld = dec_vld_reg;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: vector table on a 4-bit wrapping counter,
// hand sequences for saturation, an 8-bit random walk, and the optional decode port.
module tb_gray_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, up, load;
   logic [7:0] lv;
   logic [3:0] b1, g1, b0, g0;
   logic       t1, w1, t0, w0;
   logic [7:0] b8, g8;
   logic       t8, w8;

`ifdef GRAY_DECODE_EN
   logic [7:0] gin;
   logic       gvld;
   logic [3:0] d1, d0;
   logic       dv1, dv0;
   logic [7:0] d8;
   logic       dv8;
`endif

   gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) dut_w1 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
      .bin_out(b1), .gray_out(g1), .terminal(t1), .wrap(w1)
`ifdef GRAY_DECODE_EN
      , .gray_in(gin[3:0]), .gray_in_vld(gvld), .bin_dec(d1), .bin_dec_vld(dv1)
`endif
   );

   gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) dut_w0 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
      .bin_out(b0), .gray_out(g0), .terminal(t0), .wrap(w0)
`ifdef GRAY_DECODE_EN
      , .gray_in(gin[3:0]), .gray_in_vld(gvld), .bin_dec(d0), .bin_dec_vld(dv0)
`endif
   );

   gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) dut_8 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
      .bin_out(b8), .gray_out(g8), .terminal(t8), .wrap(w8)
`ifdef GRAY_DECODE_EN
      , .gray_in(gin), .gray_in_vld(gvld), .bin_dec(d8), .bin_dec_vld(dv8)
`endif
   );

   typedef struct {
      logic       rst, load, en, up;
      logic [3:0] lv;
      logic [3:0] bin, gray;
      logic       term, wrp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;

   // Hand-written 4-bit Gray codes for binary 0..15
   logic [3:0] gt [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   function automatic void add(logic r, logic l, logic e, logic u, logic [3:0] v,
                               logic [3:0] eb, logic [3:0] eg, logic et, logic ew);
      vec_t x;
      x.rst = r; x.load = l; x.en = e; x.up = u; x.lv = v;
      x.bin = eb; x.gray = eg; x.term = et; x.wrp = ew;
      vecs.push_back(x);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic l, logic e, logic u, logic [7:0] v);
      rst = r; load = l; en = e; up = u; lv = v;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] g2b(logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic int popcnt(logic [7:0] x);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(x[i]);
      return n;
   endfunction

   initial begin
      logic [7:0] m8, pg, pb;
      logic       exp_w;
      rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; lv = '0;
`ifdef GRAY_DECODE_EN
      gin = '0; gvld = 1'b0;
`endif

      // ---- table: 4-bit wrapping counter ----
      add(1, 0, 0, 0, 0, 0, gt[0], 0, 0);
      for (int k = 1; k < 16; k++) add(0, 0, 1, 1, 0, 4'(k), gt[k], (k == 15), 0);
      add(0, 0, 1, 1, 0, 0, gt[0], 0, 1);
      add(0, 0, 1, 0, 0, 15, gt[15], 0, 1);
      add(0, 0, 1, 0, 0, 14, gt[14], 0, 0);
      add(0, 0, 0, 0, 0, 14, gt[14], 0, 0);
      add(0, 1, 1, 1, 9, 9, gt[9], 0, 0);
      add(0, 0, 1, 1, 0, 10, gt[10], 0, 0);
      add(0, 1, 0, 1, 15, 15, gt[15], 1, 0);
      add(0, 0, 0, 0, 0, 15, gt[15], 0, 0);
      add(0, 1, 0, 0, 0, 0, gt[0], 1, 0);
      add(0, 0, 0, 0, 0, 0, gt[0], 1, 0);
      add(0, 1, 0, 1, 5, 5, gt[5], 0, 0);
      add(0, 0, 1, 1, 0, 6, gt[6], 0, 0);
      add(1, 1, 1, 1, 9, 0, gt[0], 0, 0);
      add(0, 0, 1, 1, 0, 1, gt[1], 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, {4'b0, vecs[i].lv});
         $display("vec %0d: rst=%0b load=%0b en=%0b up=%0b -> bin=%0d gray=%b term=%0b wrap=%0b",
                  i, vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, b1, g1, t1, w1);
         chk($sformatf("v%0d_bin", i), 32'(b1), 32'(vecs[i].bin));
         chk($sformatf("v%0d_gray", i), 32'(g1), 32'(vecs[i].gray));
         chk($sformatf("v%0d_term", i), 32'(t1), 32'(vecs[i].term));
         chk($sformatf("v%0d_wrap", i), 32'(w1), 32'(vecs[i].wrp));
      end

      // ---- saturating counter ----
      drive(1, 0, 0, 1, 0);
      chk("sat_rst_bin", 32'(b0), 32'd0);
      drive(0, 1, 0, 1, 13);
      chk("sat_load_bin", 32'(b0), 32'd13);
      drive(0, 0, 1, 1, 0);
      chk("sat_14_bin", 32'(b0), 32'd14);
      chk("sat_14_term", 32'(t0), 32'd0);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, 1, 0);
         $display("sat up %0d: bin=%0d gray=%b term=%0b wrap=%0b", k, b0, g0, t0, w0);
         chk("sat_hi_bin", 32'(b0), 32'd15);
         chk("sat_hi_gray", 32'(g0), 32'b1000);
         chk("sat_hi_term", 32'(t0), 32'd1);
         chk("sat_hi_wrap", 32'(w0), 32'd0);
      end
      drive(0, 0, 1, 0, 0);
      chk("sat_dn_bin", 32'(b0), 32'd14);
      chk("sat_dn_term", 32'(t0), 32'd0);
      drive(0, 1, 0, 0, 1);
      chk("sat_load1_bin", 32'(b0), 32'd1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1, 0, 0);
         $display("sat down %0d: bin=%0d gray=%b term=%0b wrap=%0b", k, b0, g0, t0, w0);
         chk("sat_lo_bin", 32'(b0), 32'd0);
         chk("sat_lo_gray", 32'(g0), 32'd0);
         chk("sat_lo_term", 32'(t0), 32'd1);
         chk("sat_lo_wrap", 32'(w0), 32'd0);
      end

      // ---- 8-bit random walk with a reference count ----
      drive(1, 0, 0, 1, 0);
      chk("w8_rst_bin", 32'(b8), 32'd0);
      m8 = '0;
      for (int k = 0; k < 400; k++) begin
         logic e, u, l;
         logic [7:0] v;
         e = ($urandom_range(0, 3) != 0);
         u = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 31) == 0);
         v = 8'($urandom);
         pg = g8; pb = m8;
         exp_w = e && !l && ((u && pb == 8'hff) || (!u && pb == 8'h00));
         if (l) m8 = v;
         else if (e) m8 = u ? m8 + 8'd1 : m8 - 8'd1;
         drive(0, l, e, u, v);
         $display("walk %0d: load=%0b en=%0b up=%0b -> bin=%0d gray=%b wrap=%0b", k, l, e, u, b8, g8, w8);
         chk("w8_bin", 32'(b8), 32'(m8));
         chk("w8_pair", 32'(g2b(g8)), 32'(b8));
         chk("w8_wrap", 32'(w8), 32'(exp_w));
         if (e && !l) chk("w8_onebit", 32'(popcnt(g8 ^ pg)), 32'd1);
      end

`ifdef GRAY_DECODE_EN
      // ---- decode port sweep ----
      drive(1, 0, 0, 0, 0);
      chk("dec_rst_val", 32'(d8), 32'd0);
      chk("dec_rst_vld", 32'(dv8), 32'd0);
      gvld = 1'b1;
      for (int i = 0; i < 256; i++) begin
         gin = 8'(i);
         drive(0, 0, 0, 0, 0);
         $display("decode gray=%b -> bin_dec=%0d vld=%0b", gin, d8, dv8);
         chk("dec_val", 32'(d8), 32'(g2b(8'(i))));
         chk("dec_vld", 32'(dv8), 32'd1);
      end
      gvld = 1'b0;
      gin = 8'h05;
      drive(0, 0, 0, 0, 0);
      chk("dec_hold_val", 32'(d8), 32'(g2b(8'hff)));
      chk("dec_hold_vld", 32'(dv8), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
